// File: rtl/cordic_linear_divider_if.sv
// Operand/result bundle for cordic_linear_divider.
// The master drives x_in, y_in and z_in (divisor, dividend and accumulator seed)
// and receives x_out, y_out and z_out. There is no handshake: the slave accepts
// a new operand set every clock and returns its result a fixed number of
// clocks later.
interface cordic_linear_divider_if #(
    parameter int WIDTH = 20
);
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] z_in;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] y_out;
    logic [WIDTH-1:0] z_out;

    modport master (
        output x_in, y_in, z_in,
        input  x_out, y_out, z_out
    );

    modport slave (
        input  x_in, y_in, z_in,
        output x_out, y_out, z_out
    );
endinterface

// File: rtl/cordic_linear_divider.sv
// Fully pipelined linear-mode CORDIC in vectoring mode.
// Computes z_out = z_in + y_in / x_in in signed Q3.16 fixed point, accepting a
// new operand set every clock. x passes through unchanged and y is driven
// toward zero; its residual appears on y_out.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset; clears every pipeline stage
//   bus  slave side of cordic_linear_divider_if
//          x_in/y_in/z_in   divisor, dividend, accumulator seed
//          x_out            x_in delayed by the pipeline latency
//          y_out/z_out      saturated residual and quotient sum
// Latency is N_ITER clocks from the sampling edge to the output edge.
module cordic_linear_divider #(
    parameter int WIDTH     = 20,
    parameter int FRAC      = 16,
    parameter int SHIFT_MIN = -2,
    parameter int N_ITER    = 18
) (
    input  logic                        clk,
    input  logic                        rst,
    cordic_linear_divider_if.slave      bus
);

    // Four guard bits on x/y absorb the left shifts of the negative-k
    // iterations; two guard bits on z hold the overshoot before saturation.
    localparam int XW = WIDTH + 4;
    localparam int ZW = WIDTH + 2;

    localparam logic signed [XW-1:0] Y_HI = XW'(2**(WIDTH-1) - 1);
    localparam logic signed [XW-1:0] Y_LO = XW'(-(2**(WIDTH-1)));
    localparam logic signed [ZW-1:0] Z_HI = ZW'(2**(WIDTH-1) - 1);
    localparam logic signed [ZW-1:0] Z_LO = ZW'(-(2**(WIDTH-1)));

    // Stage i holds the operands entering iteration k = SHIFT_MIN + i.
    logic signed [XW-1:0] x_pipe [0:N_ITER-1];
    logic signed [XW-1:0] y_pipe [0:N_ITER-1];
    logic signed [ZW-1:0] z_pipe [0:N_ITER-1];

    logic signed [XW-1:0] x_sh   [0:N_ITER-1];
    logic signed [ZW-1:0] z_step [0:N_ITER-1];
    logic signed [XW-1:0] y_next [0:N_ITER-1];
    logic signed [ZW-1:0] z_next [0:N_ITER-1];

    function automatic logic [WIDTH-1:0] sat_y(input logic signed [XW-1:0] v);
        if (v > Y_HI) begin
            return Y_HI[WIDTH-1:0];
        end else if (v < Y_LO) begin
            return Y_LO[WIDTH-1:0];
        end
        return v[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_z(input logic signed [ZW-1:0] v);
        if (v > Z_HI) begin
            return Z_HI[WIDTH-1:0];
        end else if (v < Z_LO) begin
            return Z_LO[WIDTH-1:0];
        end
        return v[WIDTH-1:0];
    endfunction

    // One iteration per stage. The loop index fixes k, so every shift and
    // z increment collapses to a constant after unrolling. A zero residual
    // freezes the stage so exact quotients are not disturbed by the
    // remaining iterations. x == 0 has a clear MSB and so counts as
    // non-negative, which drives z toward the positive or negative limit.
    always_comb begin
        for (int i = 0; i < N_ITER; i++) begin
            if (SHIFT_MIN + i < 0) begin
                x_sh[i] = x_pipe[i] <<< (-(SHIFT_MIN + i));
            end else begin
                x_sh[i] = x_pipe[i] >>> (SHIFT_MIN + i);
            end
            z_step[i] = {{(ZW-1){1'b0}}, 1'b1} << (FRAC - SHIFT_MIN - i);
            y_next[i] = y_pipe[i];
            z_next[i] = z_pipe[i];
            if (y_pipe[i] != '0) begin
                if (y_pipe[i][XW-1] == x_pipe[i][XW-1]) begin
                    y_next[i] = y_pipe[i] - x_sh[i];
                    z_next[i] = z_pipe[i] + z_step[i];
                end else begin
                    y_next[i] = y_pipe[i] + x_sh[i];
                    z_next[i] = z_pipe[i] - z_step[i];
                end
            end
        end
    end

    // Stage 0 captures sign-extended inputs; each later stage captures the
    // previous stage's iteration result. The last iteration is saturated
    // and written straight into the output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ITER; i++) begin
                x_pipe[i] <= '0;
                y_pipe[i] <= '0;
                z_pipe[i] <= '0;
            end
            bus.x_out <= '0;
            bus.y_out <= '0;
            bus.z_out <= '0;
        end else begin
            x_pipe[0] <= {{4{bus.x_in[WIDTH-1]}}, bus.x_in};
            y_pipe[0] <= {{4{bus.y_in[WIDTH-1]}}, bus.y_in};
            z_pipe[0] <= {{2{bus.z_in[WIDTH-1]}}, bus.z_in};
            for (int i = 1; i < N_ITER; i++) begin
                x_pipe[i] <= x_pipe[i-1];
                y_pipe[i] <= y_next[i-1];
                z_pipe[i] <= z_next[i-1];
            end
            bus.x_out <= x_pipe[N_ITER-1][WIDTH-1:0];
            bus.y_out <= sat_y(y_next[N_ITER-1]);
            bus.z_out <= sat_z(z_next[N_ITER-1]);
        end
    end

endmodule

// File: tb/tb_cordic_linear_divider.sv
// Self-checking bench for cordic_linear_divider.
// Every clock one operand set is driven and its expected result is queued;
// the queue is pre-filled with one zero result per pipeline stage, so the
// entry popped after each edge is the one whose operands entered 18 edges
// earlier. Expected results come either from literal constants or from a
// reference model built on integer division and saturation.
module tb_cordic_linear_divider;

    localparam int WIDTH = 20;
    localparam int LAT   = 18;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
        int               id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    cordic_linear_divider_if #(.WIDTH(WIDTH)) bus ();

    cordic_linear_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Quotient model: x == 0 sends z to the +/-(8 - 2^-15) limit by the sign
    // of y and leaves y alone; otherwise the quotient is exact for the
    // operands this bench generates, so the residual is zero.
    function automatic exp_t ref_model(input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y,
                                       input logic [WIDTH-1:0] z);
        exp_t   r;
        longint xs;
        longint ys;
        longint zs;
        longint q;
        longint zr;
        xs = longint'($signed(x));
        ys = longint'($signed(y));
        zs = longint'($signed(z));
        r.x = x;
        r.id = 0;
        if (xs == 0) begin
            r.y = y;
            q = (ys > 0) ? 64'sd524286 : ((ys < 0) ? -64'sd524286 : 64'sd0);
        end else begin
            r.y = '0;
            q = (ys * 65536) / xs;
        end
        zr = zs + q;
        if (zr > 524287) zr = 524287;
        if (zr < -524288) zr = -524288;
        r.z = zr[WIDTH-1:0];
        return r;
    endfunction

    // Divisors are multiples of 0.5 so every right shift of x is exact, and
    // the quotient is a multiple of 2^-15 below 8 in magnitude; one vector
    // in eight uses a zero divisor with an arbitrary dividend.
    task automatic random_vector(output logic [WIDTH-1:0] x,
                                 output logic [WIDTH-1:0] y,
                                 output logic [WIDTH-1:0] z);
        int b;
        int a;
        int amax;
        if ($urandom_range(7) == 0) begin
            x = '0;
            y = WIDTH'($urandom);
            z = WIDTH'($urandom);
        end else begin
            do b = int'($urandom_range(30)) - 15; while (b == 0);
            amax = 524287 / ((b < 0) ? -b : b);
            if (amax > 262143) amax = 262143;
            a = int'($urandom_range(2 * amax)) - amax;
            x = WIDTH'(b * 32768);
            y = WIDTH'(a * b);
            z = WIDTH'($urandom);
        end
    endtask

    task automatic checkOutput(input string tag,
                               input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one operand set, clocks once, then checks the result that
    // leaves the pipeline on that edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y,
                                 input logic [WIDTH-1:0] z,
                                 input exp_t            e);
        exp_t got;
        bus.x_in = x;
        bus.y_in = y;
        bus.z_in = z;
        vec_id++;
        got = e;
        got.id = vec_id;
        expq.push_back(got);
        @(posedge clk);
        #1;
        got = expq.pop_front();
        checkOutput($sformatf("v%0d.x_out", got.id), bus.x_out, got.x);
        checkOutput($sformatf("v%0d.y_out", got.id), bus.y_out, got.y);
        checkOutput($sformatf("v%0d.z_out", got.id), bus.z_out, got.z);
    endtask

    task automatic apply_directed(input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y,
                                  input logic [WIDTH-1:0] z,
                                  input logic [WIDTH-1:0] ex,
                                  input logic [WIDTH-1:0] ey,
                                  input logic [WIDTH-1:0] ez);
        exp_t e;
        e.x = ex;
        e.y = ey;
        e.z = ez;
        e.id = 0;
        applyStimulus(x, y, z, e);
    endtask

    task automatic apply_random();
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
        random_vector(x, y, z);
        applyStimulus(x, y, z, ref_model(x, y, z));
    endtask

    // A fresh or flushed pipeline emits zeros for its first LAT edges.
    task automatic prime_queue();
        exp_t zero;
        zero.x = '0;
        zero.y = '0;
        zero.z = '0;
        zero.id = 0;
        expq.delete();
        for (int i = 0; i < LAT; i++) expq.push_back(zero);
    endtask

    initial begin
        bus.x_in = '0;
        bus.y_in = '0;
        bus.z_in = '0;

        // Outputs while held in reset.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.x_out", bus.x_out, 20'h00000);
        checkOutput("reset.y_out", bus.y_out, 20'h00000);
        checkOutput("reset.z_out", bus.z_out, 20'h00000);
        @(negedge clk);
        rst = 1'b1;
        prime_queue();

        // Directed vectors, back to back with no bubbles.
        apply_directed(20'h24000, 20'h48000, 20'h00000, 20'h24000, 20'h00000, 20'h20000);
        apply_directed(20'h10000, 20'hF8000, 20'h10000, 20'h10000, 20'h00000, 20'h08000);
        apply_directed(20'h00000, 20'h10000, 20'h00000, 20'h00000, 20'h10000, 20'h7FFFE);
        apply_directed(20'h10000, 20'h70000, 20'h70000, 20'h10000, 20'h00000, 20'h7FFFF);
        apply_directed(20'h00000, 20'hF0000, 20'h10000, 20'h00000, 20'hF0000, 20'h90002);
        apply_directed(20'h00000, 20'h00000, 20'h12345, 20'h00000, 20'h00000, 20'h12345);
        apply_directed(20'h08000, 20'h3FFFF, 20'h00000, 20'h08000, 20'h00000, 20'h7FFFE);
        apply_directed(20'h08000, 20'hC0001, 20'h00000, 20'h08000, 20'h00000, 20'h80002);
        apply_directed(20'h10000, 20'h90000, 20'h90000, 20'h10000, 20'h00000, 20'h80000);
        apply_directed(20'hF0000, 20'h30000, 20'h00000, 20'hF0000, 20'h00000, 20'hD0000);

        // Randomized stream against the reference model.
        repeat (200) apply_random();

        // Asynchronous reset mid-stream flushes everything at once.
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midreset.x_out", bus.x_out, 20'h00000);
        checkOutput("midreset.y_out", bus.y_out, 20'h00000);
        checkOutput("midreset.z_out", bus.z_out, 20'h00000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        prime_queue();

        // Post-reset stream: zeros for LAT edges, then fresh results only.
        repeat (60) apply_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
